// File: rtl/vec_store_stage.sv
// vec_store_stage: writeback/store stage retiring execute packets to the register file, memory bus and fetch,
// with a LIFO divergence stack that reconverges split lanes at HALT.
module vec_store_stage #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 64,
  parameter int PC_W      = 32,
  parameter int REG_ID_W  = 5,
  parameter int DQ_DEPTH  = 8,
  parameter int ID_W      = 8,
  parameter int CORE_ID   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_opcode,
  input  logic [REG_ID_W-1:0]           in_dest_reg,
  input  logic [PC_W-1:0]               in_dest_pc,
  input  logic [PC_W-1:0]               in_src_pc,
  input  logic [NUM_LANES-1:0]          in_mask_true,
  input  logic [NUM_LANES-1:0]          in_mask_false,
  input  logic [NUM_LANES*LANE_W-1:0]   in_data,
  input  logic [NUM_LANES*LANE_W-1:0]   in_addr,
  input  logic                          in_is_store_to_pc,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_write,
  output logic [NUM_LANES*LANE_W-1:0]   mem_req_addr,
  output logic [NUM_LANES*LANE_W-1:0]   mem_req_data,
  output logic [NUM_LANES-1:0]          mem_req_mask,
  output logic [ID_W-1:0]               mem_req_id,
  input  logic                          mem_rsp_valid,
  input  logic [ID_W-1:0]               mem_rsp_id,
  input  logic [NUM_LANES*LANE_W-1:0]   mem_rsp_data,
  output logic                          rf_we,
  output logic [REG_ID_W-1:0]           rf_wr_reg,
  output logic [NUM_LANES*LANE_W-1:0]   rf_wr_data,
  output logic [NUM_LANES-1:0]          rf_wr_mask,
  output logic                          fetch_valid,
  output logic [PC_W-1:0]               fetch_pc,
  output logic [NUM_LANES-1:0]          fetch_mask,
  output logic                          halted,
  output logic                          dq_overflow,
  output logic                          illegal_op,
  output logic [31:0]                   stat_divergences,
  output logic [31:0]                   stat_wait_cycles
);
  localparam int DW = NUM_LANES * LANE_W;
  localparam int AW = $clog2(DQ_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0] OP_HALT = 3'd1, OP_CJMP = 3'd2, OP_JMP = 3'd3, OP_LOAD = 3'd4,
                         OP_STORE = 3'd5, OP_SET = 3'd6, OP_ILL = 3'd7;
  typedef enum logic [1:0] {IDLE, MEM_REQ, WAIT_RSP, HALTED} state_t;
  typedef struct packed {
    state_t                st;
    logic                  rdy;
    logic                  hlt;
    logic                  rv;
    logic                  rw;
    logic [DW-1:0]         ra;
    logic [DW-1:0]         rd;
    logic [NUM_LANES-1:0]  rm;
    logic                  we;
    logic [REG_ID_W-1:0]   wreg;
    logic [DW-1:0]         wdata;
    logic [NUM_LANES-1:0]  wmask;
    logic                  fv;
    logic [PC_W-1:0]       fpc;
    logic [NUM_LANES-1:0]  fmask;
    logic                  ovf;
    logic                  ill;
    logic [31:0]           div;
    logic [31:0]           wcyc;
    logic [CW-1:0]         cnt;
    logic [REG_ID_W-1:0]   lreg;
    logic [NUM_LANES-1:0]  lmask;
    logic                  lpc;
  } regs_t;
  regs_t r_q, r_d;
  logic [PC_W-1:0]      stk_pc [DQ_DEPTH];
  logic [NUM_LANES-1:0] stk_mask [DQ_DEPTH];
  logic                 push;
  logic                 split;
  logic                 rsp_hit;
  logic [CW-1:0]        top;
  logic [PC_W-1:0]      lane_pc;
  always_comb begin
    r_d     = r_q;
    r_d.we  = 1'b0;
    r_d.fv  = 1'b0;
    push    = 1'b0;
    split   = |in_mask_true && |in_mask_false;
    rsp_hit = mem_rsp_valid && mem_rsp_id == ID_W'(CORE_ID);
    top     = r_q.cnt - 1'b1;
    lane_pc = mem_rsp_data[PC_W-1:0];
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (r_q.lmask[i]) lane_pc = mem_rsp_data[i*LANE_W +: PC_W];
    case (r_q.st)
      IDLE: if (in_valid && r_q.rdy) begin
        case (in_opcode)
          OP_HALT: begin
            if (r_q.cnt != '0) begin
              r_d.fv    = 1'b1;
              r_d.fpc   = stk_pc[top[AW-1:0]];
              r_d.fmask = stk_mask[top[AW-1:0]];
              r_d.cnt   = top;
            end else r_d.st = HALTED;
          end
          OP_CJMP: begin
            r_d.fv    = 1'b1;
            r_d.fpc   = (|in_mask_true && !split) ? in_dest_pc : in_src_pc;
            r_d.fmask = (|in_mask_true && !split) ? in_mask_true : in_mask_false;
            if (split && ~&r_q.div) r_d.div = r_q.div + 1'b1;
            // A full stack drops the taken half; its lanes are lost but execution continues.
            if (split && r_q.cnt == CW'(DQ_DEPTH)) r_d.ovf = 1'b1;
            else if (split) begin
              push    = 1'b1;
              r_d.cnt = r_q.cnt + 1'b1;
            end
          end
          OP_JMP: begin
            r_d.fv    = 1'b1;
            r_d.fpc   = in_dest_pc;
            r_d.fmask = in_mask_true;
          end
          OP_LOAD, OP_STORE: begin
            r_d.st    = MEM_REQ;
            r_d.rv    = 1'b1;
            r_d.rw    = in_opcode == OP_STORE;
            r_d.ra    = in_addr;
            r_d.rd    = in_opcode == OP_STORE ? in_data : '0;
            r_d.rm    = in_mask_true;
            r_d.lreg  = in_dest_reg;
            r_d.lmask = in_mask_true;
            r_d.lpc   = in_is_store_to_pc;
          end
          OP_SET: begin
            r_d.we    = 1'b1;
            r_d.wreg  = in_dest_reg;
            r_d.wdata = in_data;
            r_d.wmask = in_mask_true;
          end
          OP_ILL: r_d.ill = 1'b1;
          default: ;
        endcase
      end
      MEM_REQ: if (mem_req_ready) begin
        r_d.rv = 1'b0;
        r_d.st = r_q.rw ? IDLE : WAIT_RSP;
      end
      WAIT_RSP: if (rsp_hit) begin
        r_d.we    = 1'b1;
        r_d.wreg  = r_q.lreg;
        r_d.wdata = mem_rsp_data;
        r_d.wmask = r_q.lmask;
        r_d.fv    = r_q.lpc;
        r_d.fpc   = r_q.lpc ? lane_pc : r_q.fpc;
        r_d.fmask = r_q.lpc ? r_q.lmask : r_q.fmask;
        r_d.st    = IDLE;
      end else if (~&r_q.wcyc) r_d.wcyc = r_q.wcyc + 1'b1;
      default: ;
    endcase
    r_d.rdy = r_d.st == IDLE;
    r_d.hlt = r_d.st == HALTED;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= '0;
    else r_q <= r_d;
  // Stack storage needs no reset: the occupancy counter alone defines validity.
  always_ff @(posedge clk)
    if (push) begin
      stk_pc[r_q.cnt[AW-1:0]]   <= in_dest_pc;
      stk_mask[r_q.cnt[AW-1:0]] <= in_mask_true;
    end
  assign in_ready         = r_q.rdy;
  assign halted           = r_q.hlt;
  assign mem_req_valid    = r_q.rv;
  assign mem_req_write    = r_q.rw;
  assign mem_req_addr     = r_q.ra;
  assign mem_req_data     = r_q.rd;
  assign mem_req_mask     = r_q.rm;
  assign mem_req_id       = ID_W'(CORE_ID);
  assign rf_we            = r_q.we;
  assign rf_wr_reg        = r_q.wreg;
  assign rf_wr_data       = r_q.wdata;
  assign rf_wr_mask       = r_q.wmask;
  assign fetch_valid      = r_q.fv;
  assign fetch_pc         = r_q.fpc;
  assign fetch_mask       = r_q.fmask;
  assign dq_overflow      = r_q.ovf;
  assign illegal_op       = r_q.ill;
  assign stat_divergences = r_q.div;
  assign stat_wait_cycles = r_q.wcyc;
endmodule

// File: doc/vec_store_stage.md
Name: vec_store_stage

Overview:
- Parametrised writeback/store stage that sits between the execute stage and the register file, the vector memory bus and the fetch stage.
- It retires one execute packet at a time:
  - register writes with per-lane write masks
  - vector loads and stores over a valid/ready memory bus
  - jumps, and conditional jumps whose lanes split
  - halt
- Divergent branches are handled by an internal divergence stack of parametrised depth. The stack reconverges lanes at HALT, and it reports overflow and stall statistics.

Parameters:
- NUM_LANES, 4, vector lanes per packet
- LANE_W, 64, bits per lane value/address
- PC_W, 32, program counter width
- REG_ID_W, 5, register index width
- DQ_DEPTH, 8, divergence stack entries (power of two, ≥2)
- ID_W, 8, memory bus transaction id width
- CORE_ID, 0, constant driven on mem_req_id; also the only accepted mem_rsp_id

Ports:
- Clock and reset:
  - clk  in  1  clock
  - rst_n  in  1  asynchronous active-low reset
- Input packet from execute:
  - in_valid  in  1  packet valid
  - in_ready  out  1  stage can accept
  - in_opcode  in  3  0 NOP, 1 HALT, 2 CJMP, 3 JMP, 4 LOAD, 5 STORE, 6 SET_REG, 7 illegal
  - in_dest_reg  in  REG_ID_W  destination register
  - in_dest_pc  in  PC_W  jump / taken target
  - in_src_pc  in  PC_W  not-taken target
  - in_mask_true  in  NUM_LANES  exec mask (taken lanes for CJMP)
  - in_mask_false  in  NUM_LANES  not-taken lanes (CJMP only)
  - in_data  in  NUM_LANES*LANE_W  store/set data
  - in_addr  in  NUM_LANES*LANE_W  per-lane memory address
  - in_is_store_to_pc  in  1  LOAD also redirects fetch
- Memory request/response:
  - mem_req_valid  out  1
  - mem_req_ready  in  1
  - mem_req_write  out  1
  - mem_req_addr  out  NUM_LANES*LANE_W
  - mem_req_data  out  NUM_LANES*LANE_W
  - mem_req_mask  out  NUM_LANES
  - mem_req_id  out  ID_W
  - mem_rsp_valid  in  1
  - mem_rsp_id  in  ID_W
  - mem_rsp_data  in  NUM_LANES*LANE_W
- Register file write:
  - rf_we  out  1
  - rf_wr_reg  out  REG_ID_W
  - rf_wr_data  out  NUM_LANES*LANE_W
  - rf_wr_mask  out  NUM_LANES
- Fetch redirect:
  - fetch_valid  out  1
  - fetch_pc  out  PC_W
  - fetch_mask  out  NUM_LANES
- Status and statistics:
  - halted  out  1
  - dq_overflow  out  1  sticky
  - illegal_op  out  1  sticky
  - stat_divergences  out  32
  - stat_wait_cycles  out  32

Behaviour:
- Reset (asynchronous, any state including a load in flight):
  - All outputs go to 0. State becomes IDLE and the stack is emptied.
  - A response arriving after reset is ignored.
- States: IDLE, MEM_REQ, WAIT_RSP, HALTED.
- Input handshake:
  - in_ready = 1 only in IDLE.
  - A packet is accepted on in_valid && in_ready in cycle T.
- Output timing:
  - All outputs are registered.
  - rf_we and fetch_valid are single-cycle pulses.
- Single-cycle ops (pulse in T+1, state stays IDLE):
  - NOP: no effect.
  - SET_REG: rf_we with reg = in_dest_reg, data = in_data, mask = in_mask_true.
  - JMP: fetch_valid with pc = in_dest_pc, mask = in_mask_true.
  - Illegal opcode 7: illegal_op set (sticky); otherwise treated as NOP.
- CJMP:
  - If mask_true == 0: fetch (in_src_pc, mask_false).
  - Else if mask_false == 0: fetch (in_dest_pc, mask_true).
  - Else (true split):
    - Push {in_dest_pc, mask_true} onto the stack.
    - Fetch (in_src_pc, mask_false).
    - stat_divergences += 1.
  - Stack full on push: entry dropped, dq_overflow set, fetch still issued.
- HALT:
  - Stack non-empty: pop the top entry (LIFO) and fetch_valid with its pc/mask in T+1; stay IDLE.
  - Stack empty: go to HALTED in T+1.
  - HALTED: halted = 1, in_ready = 0; left only by reset.
- STORE:
  - T+1: enter MEM_REQ and assert mem_req_valid with write = 1, addr = in_addr, data = in_data, mask = in_mask_true, id = CORE_ID.
  - Hold all request fields stable until mem_req_ready.
  - The cycle after the handshake returns to IDLE; no response is expected.
- LOAD:
  - Issue the request as for STORE with write = 0 and data = 0.
  - After the handshake, enter WAIT_RSP.
  - Matching response (mem_rsp_valid && mem_rsp_id == CORE_ID), next cycle:
    - rf_we with reg = in_dest_reg, data = mem_rsp_data, mask = in_mask_true.
    - If in_is_store_to_pc: also fetch_valid in the same cycle, pc = low PC_W bits of the lowest-indexed active lane, mask = in_mask_true.
    - Return to IDLE.
  - Non-matching responses are ignored.
  - stat_wait_cycles += 1 on every WAIT_RSP cycle without a matching response.
- Stack:
  - Occupancy counter 0..DQ_DEPTH with no wrap.
  - Pop when empty never occurs (guarded by the empty check).
- Statistics counters saturate at all-ones.

Test Plan:
- JMP accepted in cycle 5 with dest_pc = 0x40 and mask_true = 4'b1011 -> cycle 6: fetch_valid = 1, fetch_pc = 0x40, fetch_mask = 4'b1011; cycle 7: fetch_valid = 0.
- CJMP with dest = 0x100, src = 0x80, true = 4'b0011, false = 4'b1100; then HALT; then HALT ->
  - CJMP: fetch (0x80, 4'b1100), stat_divergences = 1.
  - First HALT: fetch (0x100, 4'b0011).
  - Second HALT: halted = 1 and in_ready = 0.
- CJMP with true = 4'b0000 and false = 4'b1111 -> fetch (src, 4'b1111), no push, stat_divergences unchanged.
- Push 9 split CJMPs with DQ_DEPTH = 8:
  - The 9th sets dq_overflow.
  - Then 9 HALTs -> 8 pops in reverse push order, and the 9th HALT halts.
- LOAD to r3, mask 4'b0101, is_store_to_pc = 1; mem_req_ready held low 3 cycles; wrong-id response, then matching response with lane0 = 0x200 ->
  - Request fields stay stable during the stall.
  - The wrong-id response is ignored.
  - rf_we on r3 with mask 4'b0101; fetch pc = 0x200.
  - stat_wait_cycles equals the cycles spent in WAIT_RSP without the matching response.
- rst_n asserted during WAIT_RSP, then a response arrives -> outputs 0, in_ready = 1 after release, no rf_we, stack empty.
